// File: rtl/lut_neuron_pkg.sv
// lut_neuron_pkg: shared FSM states, table sizing and parity helper for lut_neuron_array (parity used only with LUT_PARITY_EN)
package lut_neuron_pkg;
    typedef enum logic [1:0] {RUN, DRAIN_CFG, CFG} state_e;
    localparam int DEF_FAN_IN = 6;
    localparam int DEF_ENTRIES = 1 << DEF_FAN_IN;
    function automatic int lut_entries(input int fan_in);
        return 1 << fan_in;
    endfunction
    function automatic logic even_par(input logic [31:0] v);
        return ^v;
    endfunction
endpackage

// File: rtl/lut_neuron_cell.sv
// lut_neuron_cell: one neuron's reprogrammable truth table; optional parity storage/check under LUT_PARITY_EN
module lut_neuron_cell import lut_neuron_pkg::*; #(
    parameter int FAN_IN   = 6,
    parameter int OUT_BITS = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_en_i,
    input  logic [FAN_IN-1:0]   wr_addr_i,
    input  logic [OUT_BITS-1:0] wr_data_i,
    input  logic [FAN_IN-1:0]   rd_addr_i,
    output logic [OUT_BITS-1:0] rd_data_o,
    output logic                par_err_o
);
    localparam int ENTRIES = lut_entries(FAN_IN);
    logic [OUT_BITS-1:0] tbl_q [ENTRIES];
    // table write port; reset clears every entry so unwritten entries read 0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) tbl_q[i] <= '0;
        end else if (wr_en_i) begin
            tbl_q[wr_addr_i] <= wr_data_i;
        end
    end
    assign rd_data_o = tbl_q[rd_addr_i];
`ifdef LUT_PARITY_EN
    logic par_q [ENTRIES];
    // parity bit captured alongside each entry; zero matches all-zero reset data
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) par_q[i] <= 1'b0;
        end else if (wr_en_i) begin
            par_q[wr_addr_i] <= even_par(32'(wr_data_i));
        end
    end
    assign par_err_o = even_par(32'(rd_data_o)) != par_q[rd_addr_i];
`else
    assign par_err_o = 1'b0;
`endif
endmodule

// File: rtl/lut_neuron_array.sv
// lut_neuron_array: 2-stage valid/ready array of run-time loadable LUT neurons; LUT_PARITY_EN enables table parity
module lut_neuron_array import lut_neuron_pkg::*; #(
    parameter int NEURONS  = 8,
    parameter int FAN_IN   = 6,
    parameter int OUT_BITS = 1,
    localparam int NW      = (NEURONS > 1) ? $clog2(NEURONS) : 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         cfg_valid,
    output logic                         cfg_ready,
    input  logic [NW-1:0]                cfg_neuron,
    input  logic [FAN_IN-1:0]            cfg_entry,
    input  logic [OUT_BITS-1:0]          cfg_data,
    input  logic                         cfg_last,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [NEURONS*FAN_IN-1:0]    in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [NEURONS*OUT_BITS-1:0]  out_data,
    output logic                         par_err
);
    state_e state_q, state_d;
    logic s1_valid_q, s2_valid_q, par_err_q;
    logic [NEURONS*FAN_IN-1:0] s1_data_q;
    logic [NEURONS*OUT_BITS-1:0] s2_data_q, lut_val;
    logic [NEURONS-1:0] lut_perr;
    logic s2_load, empty;

    assign s2_load = !s2_valid_q || out_ready;
    assign empty   = !s1_valid_q && !s2_valid_q;

    for (genvar n = 0; n < NEURONS; n++) begin : g_cell
        lut_neuron_cell #(.FAN_IN(FAN_IN), .OUT_BITS(OUT_BITS)) u_cell (
            .clk       (clk),
            .rst       (rst),
            .wr_en_i   (cfg_ready && cfg_valid && cfg_neuron == NW'(n)),
            .wr_addr_i (cfg_entry),
            .wr_data_i (cfg_data),
            .rd_addr_i (s1_data_q[n*FAN_IN +: FAN_IN]),
            .rd_data_o (lut_val[n*OUT_BITS +: OUT_BITS]),
            .par_err_o (lut_perr[n])
        );
    end

    // next state and handshakes; a pending config beat blocks new inputs so the pipeline drains
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        cfg_ready = 1'b0;
        case (state_q)
            RUN: begin
                in_ready = !cfg_valid && (!s1_valid_q || s2_load);
                if (cfg_valid && empty) state_d = DRAIN_CFG;
            end
            DRAIN_CFG: state_d = CFG;
            CFG: begin
                cfg_ready = 1'b1;
                if (cfg_valid && cfg_last) state_d = RUN;
            end
            default: state_d = RUN;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= RUN;
        else     state_q <= state_d;
    end

    // S1 captures indices, S2 captures lookups; parity errors latch until reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
            par_err_q  <= 1'b0;
        end else begin
            if (in_valid && in_ready) begin
                s1_valid_q <= 1'b1;
                s1_data_q  <= in_data;
            end else if (s2_load) begin
                s1_valid_q <= 1'b0;
            end
            if (s2_load) begin
                s2_valid_q <= s1_valid_q;
                if (s1_valid_q) s2_data_q <= lut_val;
            end
            if (s2_load && s1_valid_q && |lut_perr) par_err_q <= 1'b1;
        end
    end

    assign out_valid = s2_valid_q;
    assign out_data  = s2_data_q;
    assign par_err   = par_err_q;
endmodule
